// File: rtl/dsound_pkg.sv
// Shared types and byte-width constants for the Direct Sound read path.
// No logic. There is no latency or backpressure here.
package dsound_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        CAPTURE = 2'd2
    } rd_state_t;

    localparam int HALF_BYTES = 2;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dsound_unpack.sv
// Holding register, byte shifter and underrun mux: one halfword becomes two samples, low byte first.
// Latency: sample_o updates 1 cycle after tick. No backpressure; an empty tick underruns.
// DSOUND_UNDERRUN_HOLD_EN: an underrun repeats the last sample instead of emitting 0x00.
module dsound_unpack
    import dsound_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        load,
    input  logic [15:0] load_dat,
    input  logic        tick,
    output logic [1:0]  hold_cnt,
    output logic [7:0]  sample,
    output logic        sample_vld,
    output logic        underrun
);

    logic [15:0] hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold       <= 16'h0000;
            hold_cnt   <= 2'd0;
            sample     <= 8'h00;
            sample_vld <= 1'b0;
            underrun   <= 1'b0;
        end else if (clr) begin
            // sample keeps its last value across a clear
            hold       <= 16'h0000;
            hold_cnt   <= 2'd0;
            sample_vld <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            sample_vld <= tick;
            if (tick) begin
                if (hold_cnt != 2'd0) begin
                    sample   <= hold[7:0];
                    hold     <= {8'h00, hold[15:8]};
                    hold_cnt <= hold_cnt - 2'd1;
                end else begin
                    underrun <= 1'b1;
`ifdef DSOUND_UNDERRUN_HOLD_EN
                    sample   <= sample;
`else
                    sample   <= 8'h00;
`endif
                end
            end
            // a load only ever lands while the register is empty
            if (load) begin
                hold     <= load_dat;
                hold_cnt <= 2'(HALF_BYTES);
            end
        end
    end

endmodule

// File: rtl/dsound_fifo_reader.sv
// Direct Sound buffer read controller: pointers, port B fetch FSM, level/DMA/error accounting.
// Latency: refill 3 cycles (IDLE->FETCH->CAPTURE); samples 1 cycle after tick; level 1 cycle after write.
// No backpressure: writes past capacity set overflow, ticks on empty set underrun (see DSOUND_UNDERRUN_HOLD_EN).
module dsound_fifo_reader
    import dsound_pkg::*;
#(
    parameter int WORDS      = 2,
    parameter int DMA_THRESH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          fifo_clr_i,
    input  logic                          wr_word_i,
    output logic [$clog2(WORDS)-1:0]      wr_ptr_o,
    input  logic                          timer_tick_i,
    output logic                          dpb_ceb_o,
    output logic [$clog2(2*WORDS)-1:0]    dpb_adb_o,
    input  logic [15:0]                   dpb_doutb_i,
    output logic [7:0]                    sample_o,
    output logic                          sample_valid_o,
    output logic [$clog2(4*WORDS):0]      level_o,
    output logic                          dma_req_o,
    output logic                          underrun_o,
    output logic                          overflow_o
);

    localparam int PW = $clog2(WORDS);
    localparam int AW = $clog2(2*WORDS);
    localparam int LW = $clog2(4*WORDS) + 1;

    localparam logic [LW:0] HB  = (LW+1)'(HALF_BYTES);
    localparam logic [LW:0] WB  = (LW+1)'(WORD_BYTES);
    localparam logic [LW:0] CAP = (LW+1)'(4*WORDS);
    localparam logic [LW:0] THR = (LW+1)'(DMA_THRESH);

    rd_state_t      state, state_next;
    logic [AW-1:0]  rd_ptr;
    logic [LW-1:0]  buf_bytes, buf_next, level_next;
    logic [LW:0]    buf_sum;
    logic [1:0]     hold_cnt, hold_cnt_next;
    logic           fetch, capture, ovf_hit, dma_next;

    assign fetch   = (state == IDLE) && (hold_cnt == 2'd0) && ({1'b0, buf_bytes} >= HB);
    assign capture = (state == CAPTURE);
    assign ovf_hit = wr_word_i && (({1'b0, buf_bytes} + WB) > CAP);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (fetch) state_next = FETCH;
            FETCH:   state_next = CAPTURE;
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // a simultaneous write and fetch net out before saturation is applied
    always_comb begin
        buf_sum = {1'b0, buf_bytes};
        if (wr_word_i) buf_sum = buf_sum + WB;
        if (fetch)     buf_sum = buf_sum - HB;
        buf_next = (buf_sum > CAP) ? CAP[LW-1:0] : buf_sum[LW-1:0];
    end

    // level as it will stand after this cycle, so the DMA decision sees the tick's effect
    always_comb begin
        hold_cnt_next = hold_cnt;
        if (capture)
            hold_cnt_next = 2'(HALF_BYTES);
        else if (timer_tick_i && hold_cnt != 2'd0)
            hold_cnt_next = hold_cnt - 2'd1;
        level_next = buf_next + {{(LW-2){1'b0}}, hold_cnt_next};
        dma_next   = timer_tick_i && ({1'b0, level_next} <= THR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else if (fifo_clr_i)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr_o   <= '0;
            buf_bytes  <= '0;
            level_o    <= '0;
            dpb_ceb_o  <= 1'b0;
            dpb_adb_o  <= '0;
            dma_req_o  <= 1'b0;
            overflow_o <= 1'b0;
        end else if (fifo_clr_i) begin
            rd_ptr     <= '0;
            wr_ptr_o   <= '0;
            buf_bytes  <= '0;
            level_o    <= '0;
            dpb_ceb_o  <= 1'b0;
            dpb_adb_o  <= '0;
            dma_req_o  <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            buf_bytes <= buf_next;
            level_o   <= level_next;
            dpb_ceb_o <= fetch;
            dma_req_o <= dma_next;
            if (wr_word_i) wr_ptr_o <= wr_ptr_o + PW'(1);
            if (ovf_hit)   overflow_o <= 1'b1;
            if (fetch) begin
                dpb_adb_o <= rd_ptr;
                rd_ptr    <= rd_ptr + AW'(1);
            end
        end
    end

    dsound_unpack u_unpack (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (fifo_clr_i),
        .load       (capture),
        .load_dat   (dpb_doutb_i),
        .tick       (timer_tick_i),
        .hold_cnt   (hold_cnt),
        .sample     (sample_o),
        .sample_vld (sample_valid_o),
        .underrun   (underrun_o)
    );

endmodule

// File: tb/tb_dsound_fifo_reader.sv
// Directed bench for dsound_fifo_reader (WORDS=2, DMA_THRESH=4) with a port-B RAM model;
// samples and DMA pulses are checked by a scoreboard monitor, flags/level by direct checks.
module tb_dsound_fifo_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_clr_i = 1'b0;
    logic        wr_word_i = 1'b0;
    logic [0:0]  wr_ptr_o;
    logic        timer_tick_i = 1'b0;
    logic        dpb_ceb_o;
    logic [1:0]  dpb_adb_o;
    logic [15:0] dpb_doutb_i;
    logic [7:0]  sample_o;
    logic        sample_valid_o;
    logic [3:0]  level_o;
    logic        dma_req_o;
    logic        underrun_o;
    logic        overflow_o;

    logic [31:0] wr_dat = 32'h0;
    logic [31:0] mem [2];

    typedef struct {
        logic [7:0] s;
        logic       d;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

`ifdef DSOUND_UNDERRUN_HOLD_EN
    localparam logic [7:0] UV3 = 8'h7F;
    localparam logic [7:0] UV5 = 8'h7F;
    localparam logic [7:0] UV6 = 8'h22;
`else
    localparam logic [7:0] UV3 = 8'h00;
    localparam logic [7:0] UV5 = 8'h00;
    localparam logic [7:0] UV6 = 8'h00;
`endif

    always #5 clk = ~clk;

    dsound_fifo_reader #(.WORDS(2), .DMA_THRESH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fifo_clr_i     (fifo_clr_i),
        .wr_word_i      (wr_word_i),
        .wr_ptr_o       (wr_ptr_o),
        .timer_tick_i   (timer_tick_i),
        .dpb_ceb_o      (dpb_ceb_o),
        .dpb_adb_o      (dpb_adb_o),
        .dpb_doutb_i    (dpb_doutb_i),
        .sample_o       (sample_o),
        .sample_valid_o (sample_valid_o),
        .level_o        (level_o),
        .dma_req_o      (dma_req_o),
        .underrun_o     (underrun_o),
        .overflow_o     (overflow_o)
    );

    // Audio_DPB model: word writes on A, registered halfword reads on B
    always @(posedge clk) begin
        if (wr_word_i) mem[wr_ptr_o] <= wr_dat;
        if (dpb_ceb_o)
            dpb_doutb_i <= dpb_adb_o[0] ? mem[dpb_adb_o[1]][31:16] : mem[dpb_adb_o[1]][15:0];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (sample_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_sample", 32'(sample_o), 32'h1FF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_sample", 32'(sample_o), 32'(e.s));
                    check("sb_dma", 32'(dma_req_o), 32'(e.d));
                end
            end else begin
                check("dma_without_tick", 32'(dma_req_o), 32'h0);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write(input logic [31:0] w);
        wr_dat = w;
        wr_word_i = 1'b1;
        @(negedge clk);
        wr_word_i = 1'b0;
    endtask

    task automatic tick(input logic [7:0] s, input logic d);
        exp_t e;
        e.s = s;
        e.d = d;
        exp_q.push_back(e);
        timer_tick_i = 1'b1;
        @(negedge clk);
        timer_tick_i = 1'b0;
    endtask

    task automatic clear();
        fifo_clr_i = 1'b1;
        @(negedge clk);
        fifo_clr_i = 1'b0;
    endtask

    logic [7:0] t2_bytes [6];
    logic       t2_dma   [6];

    initial begin
        t2_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        t2_dma   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        cyc(3);
        rst_n = 1'b1;
        cyc(1);
        check("rst_sample", 32'(sample_o), 0);
        check("rst_level", 32'(level_o), 0);
        check("rst_flags", {underrun_o, overflow_o, dpb_ceb_o}, 0);
        check("rst_ptrs", {wr_ptr_o, dpb_adb_o}, 0);

        // one word, four spaced ticks, little-endian order
        write(32'h44332211);
        check("t1_level_wr", 32'(level_o), 4);
        check("t1_wr_ptr", 32'(wr_ptr_o), 1);
        cyc(6);
        check("t1_level_refill", 32'(level_o), 4);
        for (int i = 0; i < 4; i++) begin
            tick(t2_bytes[i], 1'b1);
            cyc(7);
            check("t1_level", 32'(level_o), 32'(3 - i));
        end
        check("t1_underrun", 32'(underrun_o), 0);

        // two words, DMA requests start once level reaches the threshold
        clear();
        write(32'h44332211);
        write(32'h88776655);
        cyc(4);
        check("t2_level_full", 32'(level_o), 8);
        for (int i = 0; i < 6; i++) begin
            tick(t2_bytes[i], t2_dma[i]);
            cyc(7);
            check("t2_level", 32'(level_o), 32'(7 - i));
        end

        // drain to empty with last sample 0x7F, then underrun
        clear();
        write(32'h7F000000);
        cyc(5);
        tick(8'h00, 1'b1); cyc(7);
        tick(8'h00, 1'b1); cyc(7);
        tick(8'h00, 1'b1); cyc(7);
        tick(8'h7F, 1'b1); cyc(7);
        check("t3_no_underrun_yet", 32'(underrun_o), 0);
        tick(UV3, 1'b1);
        cyc(3);
        check("t3_underrun", 32'(underrun_o), 1);
        check("t3_level", 32'(level_o), 0);

        // three back-to-back writes into a two-word buffer
        clear();
        check("t4_clr_underrun", 32'(underrun_o), 0);
        write(32'hA3A2A1A0);
        write(32'hB3B2B1B0);
        write(32'hC3C2C1C0);
        check("t4_overflow", 32'(overflow_o), 1);
        check("t4_level", 32'(level_o), 8);
        check("t4_wr_ptr", 32'(wr_ptr_o), 1);

        // clear lands in the FETCH cycle of the second halfword
        clear();
        check("t5_clr_overflow", 32'(overflow_o), 0);
        tick(UV5, 1'b1);
        cyc(3);
        check("t5_underrun_set", 32'(underrun_o), 1);
        write(32'h44332211);
        cyc(5);
        tick(8'h11, 1'b1);
        cyc(7);
        tick(8'h22, 1'b1);
        cyc(1);
        check("t5_fetch_ceb", 32'(dpb_ceb_o), 1);
        check("t5_fetch_adb", 32'(dpb_adb_o), 1);
        clear();
        check("t5_adb_cleared", 32'(dpb_adb_o), 0);
        check("t5_flags_cleared", {underrun_o, overflow_o}, 0);
        cyc(5);
        check("t5_level_discarded", 32'(level_o), 0);
        check("t5_ceb_idle", 32'(dpb_ceb_o), 0);

        // ticks in the CAPTURE cycle and the one after
        clear();
        write(32'h44332211);
        cyc(1);
        check("t6_fetch_ceb", 32'(dpb_ceb_o), 1);
        cyc(1);
        tick(UV6, 1'b1);
        tick(8'h11, 1'b1);
        check("t6_underrun", 32'(underrun_o), 1);
        cyc(6);
        tick(8'h22, 1'b1);
        cyc(10);
        check("t6_level", 32'(level_o), 2);
        check("sb_drain", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
